// File: rtl/turing_pkg.sv
// turing_pkg: shared encodings for the Turing engine (moves, halt reasons, FSM states).
package turing_pkg;

    typedef enum logic [1:0] {
        MV_LEFT  = 2'b00,
        MV_RIGHT = 2'b01,
        MV_STAY  = 2'b10,
        MV_HALT  = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        HR_HALT       = 2'b00,
        HR_LEFT_EDGE  = 2'b01,
        HR_RIGHT_EDGE = 2'b10,
        HR_STEP_LIMIT = 2'b11
    } halt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PAUSE,
        S_EXEC,
        S_DONE
    } fsm_t;

endpackage

// File: rtl/turing_engine_transition_table.sv
// transition_table: NS*2^SW entry rule memory, synchronous write, asynchronous read.
module transition_table #(
    parameter int SW = 2,
    parameter int SB = 3,
    parameter int NS = 8
) (
    input  logic               clock,
    input  logic               we,
    input  logic [SB+SW-1:0]   waddr,
    input  logic [SW+SB+1:0]   wdata,
    input  logic [SB+SW-1:0]   raddr,
    output logic [SW+SB+1:0]   rdata
);
    localparam int AW = SB + SW;
    localparam int DEPTH = NS << SW;
    localparam logic [AW:0] LIM = (AW + 1)'(DEPTH);

    logic [SW+SB+1:0] mem [DEPTH];

    // Addresses naming a state >= NS fall outside the table when NS is not a power of two.
    always_ff @(posedge clock)
        if (we && {1'b0, waddr} < LIM) mem[waddr] <= wdata;

    assign rdata = ({1'b0, raddr} < LIM) ? mem[raddr] : '0;
endmodule

// File: rtl/turing_engine.sv
// turing_engine: single-tape Turing machine with host-programmable table and tape,
// free-running at two cycles per step or paced by step pulses.
module turing_engine
    import turing_pkg::*;
#(
    parameter int SW = 2,
    parameter int NS = 8,
    parameter int TL = 32,
    parameter int MAX_STEPS = 255,
    localparam int SB = (NS > 1) ? $clog2(NS) : 1,
    localparam int AB = $clog2(TL),
    localparam int CW = $clog2(MAX_STEPS + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               prog_valid,
    output logic               prog_ready,
    input  logic [SB+SW-1:0]   prog_addr,
    input  logic [SW+SB+1:0]   prog_data,
    input  logic               tape_we,
    input  logic [AB-1:0]      tape_addr,
    input  logic [SW-1:0]      tape_wdata,
    input  logic [AB-1:0]      rd_addr,
    output logic [SW-1:0]      rd_data,
    input  logic               start,
    input  logic [AB-1:0]      start_head,
    input  logic               abort,
    input  logic               single_step,
    input  logic               step,
    output logic               busy,
    output logic               done,
    output logic [1:0]         halt_reason,
    output logic [AB-1:0]      head,
    output logic [SB-1:0]      cur_state,
    output logic [CW-1:0]      step_count
);
    localparam logic [AB-1:0] LAST = AB'(TL - 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_STEPS);

    fsm_t             st;
    logic [SW-1:0]    tape [TL];
    logic [SW+SB+1:0] ent, tbl_rd;
    logic [SW-1:0]    sym, ws;
    move_t            mv;
    logic [SB-1:0]    ns;
    logic [CW-1:0]    cnt_nx;
    logic             idle_done, host_tw, exec_wr;

    assign idle_done  = (st == S_IDLE) || (st == S_DONE);
    assign prog_ready = idle_done;
    assign busy       = (st == S_FETCH) || (st == S_PAUSE) || (st == S_EXEC);
    assign done       = (st == S_DONE);
    assign sym        = tape[head];
    assign rd_data    = tape[rd_addr];
    assign ws         = ent[SW+SB+1 -: SW];
    assign mv         = move_t'(ent[SB+1:SB]);
    assign ns         = ent[SB-1:0];
    assign cnt_nx     = step_count + CW'(1);
    assign host_tw    = tape_we && idle_done;
    assign exec_wr    = (st == S_EXEC) && (mv != MV_HALT) && !abort;

    transition_table #(.SW(SW), .SB(SB), .NS(NS)) u_table (
        .clock (clock),
        .we    (prog_valid && prog_ready),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr ({cur_state, sym}),
        .rdata (tbl_rd)
    );

    // Host and engine writes never overlap: the host is only heard in IDLE/DONE.
    always_ff @(posedge clock)
        if (host_tw) tape[tape_addr] <= tape_wdata;
        else if (exec_wr) tape[head] <= ws;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            st          <= S_IDLE;
            head        <= '0;
            cur_state   <= '0;
            step_count  <= '0;
            halt_reason <= HR_HALT;
            ent         <= '0;
        end else if (abort) begin
            st <= S_IDLE;
        end else begin
            case (st)
                S_IDLE, S_DONE:
                    if (start) begin
                        st         <= S_FETCH;
                        head       <= start_head;
                        cur_state  <= '0;
                        step_count <= '0;
                    end
                S_FETCH: begin
                    ent <= tbl_rd;
                    st  <= single_step ? S_PAUSE : S_EXEC;
                end
                S_PAUSE:
                    if (step) st <= S_EXEC;
                S_EXEC:
                    if (mv == MV_HALT) begin
                        halt_reason <= HR_HALT;
                        st          <= S_DONE;
                    end else begin
                        cur_state  <= ns;
                        step_count <= cnt_nx;
                        // Edge stops win over the step limit; the head stays put on an edge.
                        if (mv == MV_LEFT && head == '0) begin
                            halt_reason <= HR_LEFT_EDGE;
                            st          <= S_DONE;
                        end else if (mv == MV_RIGHT && head == LAST) begin
                            halt_reason <= HR_RIGHT_EDGE;
                            st          <= S_DONE;
                        end else begin
                            head <= (mv == MV_LEFT) ? head - AB'(1) : (mv == MV_RIGHT) ? head + AB'(1) : head;
                            st   <= (cnt_nx == LIMIT) ? S_DONE : S_FETCH;
                            if (cnt_nx == LIMIT) halt_reason <= HR_STEP_LIMIT;
                        end
                    end
                default: st <= S_IDLE;
            endcase
        end
endmodule
